seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits.
- Captures a packed hex value and cycles through its digits at a programmable rate.
- Drives the 4-bit digit code into the downstream seven-segment decode LUT (its 4-bit digit input) and drives the active-low digit-select lines directly.
- Value updates are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 2..8.
- SCAN_DIV, 50000: clk cycles each digit stays lit; legal range 2..2^20.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- load  in  1  single-cycle strobe; capture value.
- value  in  4*NUM_DIGITS  packed hex digits; digit 0 = value[3:0].
- dig_en  in  NUM_DIGITS  per-digit enable; 0 = digit always dark.
- nibble  out  4  digit code to the decode LUT; registered.
- blank  out  1  1 = current slot dark; segment driver must be forced off; registered.
- dig_sel  out  NUM_DIGITS  one-hot-low digit select; all-ones = none lit; registered.
- frame_done  out  1  one-cycle pulse at each frame boundary; registered.

Behaviour:
- Reset is synchronous. On a clk edge with rst_n=0:
  - prescaler cnt=0, idx=0, disp_reg=0, pend_reg=0, pend_v=0.
  - nibble=4'h0, blank=1, dig_sel=all ones, frame_done=0.
- Reset mid-scan or mid-load discards any pending value. The first lit digit after reset is digit 0, one cycle after rst_n rises.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (cnt==SCAN_DIV-1).
- Digit index:
  - On tick, idx advances to idx+1.
  - When idx==NUM_DIGITS-1, it wraps to 0 instead.
- Frame boundary: fb = tick && idx==NUM_DIGITS-1. On fb:
  - frame_done <= 1 for exactly one cycle.
  - If pend_v: disp_reg <= pend_reg, pend_v <= 0.
  - If load is also asserted in the same cycle: disp_reg <= value directly and pend_v <= 0. The new load wins over the older pending value.
- Load when not on fb: pend_reg <= value, pend_v <= 1. A later load before the boundary overwrites pend_reg; last load wins.
- Output stage (registered, computed from the current idx and disp_reg):
  - nibble <= disp_reg[4*idx+3 : 4*idx].
  - blank <= ~dig_en[idx].
  - dig_sel <= dig_en[idx] ? ~(1<<idx) : all ones.
  - Outputs therefore lag idx by one cycle. Each digit is presented for exactly SCAN_DIV cycles.
- dig_en is sampled every cycle, not latched at the frame boundary. Toggling it mid-slot takes effect on the next cycle.
- Exactly one dig_sel bit is ever low, or none. Never two.
- Full frame period = NUM_DIGITS*SCAN_DIV cycles. Refresh rate per digit = clk/(NUM_DIGITS*SCAN_DIV).
- No backpressure: load is always accepted.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined:
  - A digit is additionally blanked (blank=1, dig_sel all ones) if its nibble is 0 and every higher-index digit of disp_reg is also 0.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
  - The mask is computed from disp_reg, so it changes only at frame boundaries.
- When undefined: no zero suppression; only dig_en controls blanking.
- Port list is identical in both builds.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Reset, load value=16'h1234, dig_en=4'hF:
  - after the first frame boundary, nibble sequence is 4,3,2,1, each held 4 cycles.
  - dig_sel sequence is 1110,1101,1011,0111.
  - frame_done pulses every 16 cycles.
- Anti-tear:
  - display 16'hAAAA; load 16'h5555 at mid-frame (idx=1), then 16'h7777 at idx=2.
  - The rest of the frame shows A; the next frame shows all 7; no 5 ever appears.
- Load coincident with fb:
  - pending 16'h1111 set earlier; load 16'h2222 on the fb cycle.
  - The next frame shows 2222 and pend_v is 0 afterwards.
- dig_en=4'b1010 with value 16'h1234:
  - slots 0 and 2 show blank=1, dig_sel=1111.
  - slots 1 and 3 show nibbles 3 and 1 with dig_sel 1101 and 0111.
- rst_n low for one cycle mid-slot at idx=2 with pending valid:
  - next cycle: dig_sel=1111, blank=1, frame_done=0.
  - then digit 0 of value 0 is shown; the pending value is lost.
- SEG7_LEADING_ZERO_BLANK_EN build:
  - value 16'h0050: digits 3 and 2 blank; digits 1 and 0 show 5 and 0.
  - value 16'h0000: only digit 0 lit, showing 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Purpose: time-multiplexed scan controller for NUM_DIGITS common-anode seven-segment digits.
// Latency: outputs lag the digit index by one cycle; a loaded value is shown from the next frame boundary.
// Backpressure: none; load is always accepted (last load before a boundary wins).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   load       single-cycle strobe; capture value
//   value      packed hex digits, digit 0 = value[3:0]
//   dig_en     per-digit enable, 0 = digit always dark
//   nibble     registered digit code for the downstream decode LUT
//   blank      registered; 1 = current slot dark, segment driver forced off
//   dig_sel    registered one-hot-low digit select; all ones = none lit
//   frame_done registered one-cycle pulse at each frame boundary
//
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros
// (digit 0 is never suppressed). Port list is the same in both builds.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [3:0]              nibble,
    output logic                    blank,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pend_v;

    logic                    tick;
    logic                    fb;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    assign tick = (cnt == CNT_LAST);
    assign fb   = tick && (idx == IDX_LAST);

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lz_mask[i] is set when digit i and every digit above it are zero.
    // Bit 0 is left clear so a zero value still shows a single "0".
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_zero;

    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (disp_reg[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end

    assign lit = dig_en[idx] & ~lz_mask[idx];
`else
    assign lit = dig_en[idx];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_v     <= 1'b0;
            nibble     <= 4'h0;
            blank      <= 1'b1;
            dig_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;

            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            frame_done <= fb;

            // Display register only changes at the frame boundary so a frame
            // never mixes old and new digits. A load on the boundary itself
            // is newer than anything pending, so it goes straight to display.
            if (fb) begin
                pend_v <= 1'b0;
                if (load) begin
                    disp_reg <= value;
                end else if (pend_v) begin
                    disp_reg <= pend_reg;
                end
            end else if (load) begin
                pend_reg <= value;
                pend_v   <= 1'b1;
            end

            nibble  <= disp_reg[4*idx +: 4];
            blank   <= ~lit;
            dig_sel <= lit ? ~sel_onehot : '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose: directed scoreboard bench for seg7_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4.
// Latency: expectations are stamped with the absolute clock-edge number they apply to.
// Backpressure: none; the monitor samples every falling edge.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dig_en;
    logic [3:0]  nibble;
    logic        blank;
    logic [3:0]  dig_sel;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .dig_en    (dig_en),
        .nibble    (nibble),
        .blank     (blank),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int END_CYC = 210;

    typedef struct {
        int         cyc;
        logic [3:0] nib;
        logic       blank;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_at(input int c, input logic [3:0] n, input logic b,
                             input logic [3:0] s, input logic f);
        exp_t e;
        e.cyc   = c;
        e.nib   = n;
        e.blank = b;
        e.sel   = s;
        e.fd    = f;
        sb.push_back(e);
    endtask

    task automatic push_slot(input int c0, input logic [3:0] n, input logic b,
                             input logic [3:0] s, input logic fd_last);
        for (int i = 0; i < 4; i++) begin
            expect_at(c0 + i, n, b, s, (i == 3) ? fd_last : 1'b0);
        end
    endtask

    // Fully lit frame starting at edge c0, digit 0 first.
    task automatic push_frame(input int c0, input logic [3:0] n0, input logic [3:0] n1,
                              input logic [3:0] n2, input logic [3:0] n3);
        push_slot(c0,      n0, 1'b0, 4'b1110, 1'b0);
        push_slot(c0 + 4,  n1, 1'b0, 4'b1101, 1'b0);
        push_slot(c0 + 8,  n2, 1'b0, 4'b1011, 1'b0);
        push_slot(c0 + 12, n3, 1'b0, 4'b0111, 1'b1);
    endtask

    task automatic push_zero_frame(input int c0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push_slot(c0,      4'h0, 1'b0, 4'b1110, 1'b0);
        push_slot(c0 + 4,  4'h0, 1'b1, 4'b1111, 1'b0);
        push_slot(c0 + 8,  4'h0, 1'b1, 4'b1111, 1'b0);
        push_slot(c0 + 12, 4'h0, 1'b1, 4'b1111, 1'b1);
`else
        push_frame(c0, 4'h0, 4'h0, 4'h0, 4'h0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Present a load so that it is sampled on edge k.
    task automatic drive_load(input int k, input logic [15:0] v);
        wait_to(k - 1);
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
    endtask

    // Monitor: pops expectations whose edge has come and compares outputs.
    always @(negedge clk) begin
        if (cyc > 0) begin
            checks++;
            if ($countones(~dig_sel) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d dig_sel=%b required at most one low bit", cyc, dig_sel);
            end
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed cyc=%0d expectation for edge %0d never compared", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({nibble, blank, dig_sel, frame_done} !== {e.nib, e.blank, e.sel, e.fd}) begin
                errors++;
                $display("FAIL outputs cyc=%0d got nib=%h blank=%b sel=%b fd=%b required nib=%h blank=%b sel=%b fd=%b",
                         cyc, nibble, blank, dig_sel, frame_done, e.nib, e.blank, e.sel, e.fd);
            end
        end
        if (cyc == END_CYC) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain cyc=%0d got %0d pending expectations required 0", cyc, sb.size());
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        value  = 16'h0;
        dig_en = 4'hF;

        // Reset held over edges 1..3; released so edge 4 is the first run edge.
        expect_at(1, 4'h0, 1'b1, 4'b1111, 1'b0);
        expect_at(2, 4'h0, 1'b1, 4'b1111, 1'b0);
        expect_at(3, 4'h0, 1'b1, 4'b1111, 1'b0);
        push_zero_frame(4);
        push_frame(20, 4'h4, 4'h3, 4'h2, 4'h1);
        push_frame(36, 4'h4, 4'h3, 4'h2, 4'h1);
        wait_to(3);
        rst_n = 1'b1;
        load  = 1'b1;
        value = 16'h1234;
        step();
        load  = 1'b0;

        // Anti-tear: AAAA shown in frame 3; 5555 then 7777 loaded mid-frame.
        push_frame(52, 4'hA, 4'hA, 4'hA, 4'hA);
        drive_load(36, 16'hAAAA);
        drive_load(57, 16'h5555);
        push_frame(68, 4'h7, 4'h7, 4'h7, 4'h7);
        drive_load(61, 16'h7777);

        // Pending 1111, then 2222 exactly on the boundary edge 83.
        drive_load(73, 16'h1111);
        push_frame(84, 4'h2, 4'h2, 4'h2, 4'h2);
        push_frame(100, 4'h2, 4'h2, 4'h2, 4'h2);
        drive_load(83, 16'h2222);

        // Frame 7 shows 1234 with dig_en = 1010.
        push_slot(116, 4'h4, 1'b1, 4'b1111, 1'b0);
        push_slot(120, 4'h3, 1'b0, 4'b1101, 1'b0);
        push_slot(124, 4'h2, 1'b1, 4'b1111, 1'b0);
        push_slot(128, 4'h1, 1'b0, 4'b0111, 1'b1);
        drive_load(103, 16'h1234);
        wait_to(115);
        dig_en = 4'b1010;

        // dig_en back to all-on in the middle of slot 0 of frame 8.
        expect_at(132, 4'h4, 1'b1, 4'b1111, 1'b0);
        expect_at(133, 4'h4, 1'b1, 4'b1111, 1'b0);
        expect_at(134, 4'h4, 1'b0, 4'b1110, 1'b0);
        expect_at(135, 4'h4, 1'b0, 4'b1110, 1'b0);
        push_slot(136, 4'h3, 1'b0, 4'b1101, 1'b0);
        push_slot(140, 4'h2, 1'b0, 4'b1011, 1'b0);
        push_slot(144, 4'h1, 1'b0, 4'b0111, 1'b1);
        wait_to(133);
        dig_en = 4'hF;

        // Frame 9: pending 5678, then one-cycle reset in slot 2 (edge 157).
        wait_to(140);
        push_slot(148, 4'h4, 1'b0, 4'b1110, 1'b0);
        push_slot(152, 4'h3, 1'b0, 4'b1101, 1'b0);
        expect_at(156, 4'h2, 1'b0, 4'b1011, 1'b0);
        expect_at(157, 4'h0, 1'b1, 4'b1111, 1'b0);
        push_zero_frame(158);
        push_zero_frame(174);
        drive_load(149, 16'h5678);
        wait_to(156);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // 0050 shown in frame starting at edge 190.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push_slot(190, 4'h0, 1'b0, 4'b1110, 1'b0);
        push_slot(194, 4'h5, 1'b0, 4'b1101, 1'b0);
        push_slot(198, 4'h0, 1'b1, 4'b1111, 1'b0);
        push_slot(202, 4'h0, 1'b1, 4'b1111, 1'b1);
`else
        push_frame(190, 4'h0, 4'h5, 4'h0, 4'h0);
`endif
        drive_load(177, 16'h0050);

        wait_to(END_CYC + 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
